// File: rtl/umi_lite_to_axil_m.sv
// rtl/umi_lite_to_axil_m.sv - single-outstanding request/response to AXI-lite master bridge
module umi_lite_to_axil_m #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_prot,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [STRB_WIDTH-1:0] req_strb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,

    output logic [CNT_WIDTH-1:0]  txn_count,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RRESP = 3'd4,
        RSP   = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  aw_done;
    logic                  w_done;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            prot_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic                  write_q;

    logic                  aw_fire;
    logic                  w_fire;
    logic                  b_fire;
    logic                  ar_fire;
    logic                  r_fire;

    assign aw_fire = m_axil_awvalid & m_axil_awready;
    assign w_fire  = m_axil_wvalid  & m_axil_wready;
    assign b_fire  = m_axil_bvalid  & m_axil_bready;
    assign ar_fire = m_axil_arvalid & m_axil_arready;
    assign r_fire  = m_axil_rvalid  & m_axil_rready;

    // Payloads come straight from the request captured at acceptance.
    assign m_axil_awaddr = addr_q;
    assign m_axil_awprot = prot_q;
    assign m_axil_wdata  = data_q;
    assign m_axil_wstrb  = strb_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_arprot = prot_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; WRITE leaves as soon as both AW and W have handshaken, counting this cycle's.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_write ? WRITE : READ;
            WRITE:   if ((aw_done | aw_fire) && (w_done | w_fire)) state_next = WRESP;
            WRESP:   if (b_fire) state_next = RSP;
            READ:    if (ar_fire) state_next = RRESP;
            RRESP:   if (r_fire) state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; AW/W valids are masked once their own handshake is done.
    always_comb begin
        req_ready      = (state == IDLE);
        m_axil_awvalid = (state == WRITE) && !aw_done;
        m_axil_wvalid  = (state == WRITE) && !w_done;
        m_axil_bready  = (state == WRESP);
        m_axil_arvalid = (state == READ);
        m_axil_rready  = (state == RRESP);
        rsp_valid      = (state == RSP);
    end

    // Remember which write channels have completed; cleared whenever not in WRITE.
    always_ff @(posedge clk) begin
        if (rst || (state != WRITE)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
        end
    end

    // Capture the request on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            prot_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
        end else if ((state == IDLE) && req_valid) begin
            addr_q  <= req_addr;
            prot_q  <= req_prot;
            data_q  <= req_data;
            strb_q  <= req_strb;
            write_q <= req_write;
        end
    end

    // Capture the AXI completion into the response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data  <= '0;
            rsp_resp  <= '0;
            rsp_write <= 1'b0;
        end else if ((state == WRESP) && b_fire) begin
            rsp_data  <= '0;
            rsp_resp  <= m_axil_bresp;
            rsp_write <= write_q;
        end else if ((state == RRESP) && r_fire) begin
            rsp_data  <= m_axil_rdata;
            rsp_resp  <= m_axil_rresp;
            rsp_write <= write_q;
        end
    end

    // Count completed transactions on the response handshake, wrapping naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_count <= '0;
        end else if ((state == RSP) && rsp_ready) begin
            txn_count <= txn_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_umi_lite_to_axil_m.sv
// tb/tb_umi_lite_to_axil_m.sv - directed bench with transaction model for umi_lite_to_axil_m
module tb_umi_lite_to_axil_m;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [15:0]   req_addr = '0;
    logic [2:0]    req_prot = '0;
    logic [31:0]   req_data = '0;
    logic [3:0]    req_strb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_write;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_resp;
    logic [CW-1:0] txn_count;

    logic [15:0]   awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [15:0]   araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    umi_lite_to_axil_m #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_prot(req_prot), .req_data(req_data), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .txn_count(txn_count),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave knobs.
    int         aw_dly = 0;
    int         w_dly  = 0;
    int         ar_dly = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [1:0] rresp_cfg = 2'b00;

    // AXI-lite slave: memory with per-channel ready delays, driven on the falling edge.
    logic [31:0] smem [64];
    logic [15:0] s_awa;
    logic [15:0] s_ara;
    logic [31:0] s_wd;
    logic [3:0]  s_ws;
    logic        s_awg, s_wg, s_bhs, s_rhs;
    int          s_awc, s_wc, s_arc;

    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        s_awg = 0; s_wg = 0; s_bhs = 0; s_rhs = 0;
        s_awc = 0; s_wc = 0; s_arc = 0;
        s_awa = 0; s_ara = 0; s_wd = 0; s_ws = 0;
        for (int i = 0; i < 64; i++) smem[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                s_awg = 0; s_wg = 0; s_bhs = 0; s_rhs = 0;
                s_awc = 0; s_wc = 0; s_arc = 0;
            end else begin
                if (s_bhs) begin bvalid = 0; s_bhs = 0; end
                if (s_rhs) begin rvalid = 0; s_rhs = 0; end
                if (awready) begin
                    awready = 0; s_awg = 1;
                end else if (awvalid && !s_awg) begin
                    if (s_awc >= aw_dly) begin awready = 1; s_awc = 0; s_awa = awaddr; end
                    else s_awc++;
                end
                if (wready) begin
                    wready = 0; s_wg = 1;
                end else if (wvalid && !s_wg) begin
                    if (s_wc >= w_dly) begin wready = 1; s_wc = 0; s_wd = wdata; s_ws = wstrb; end
                    else s_wc++;
                end
                if (s_awg && s_wg && !bvalid) begin
                    for (int b = 0; b < 4; b++)
                        if (s_ws[b]) smem[s_awa[7:2]][8*b +: 8] = s_wd[8*b +: 8];
                    bvalid = 1; bresp = bresp_cfg; s_awg = 0; s_wg = 0;
                end
                if (bvalid && bready) s_bhs = 1;
                if (arready) begin
                    arready = 0; rvalid = 1; rdata = smem[s_ara[7:2]]; rresp = rresp_cfg;
                end else if (arvalid && !rvalid) begin
                    if (s_arc >= ar_dly) begin arready = 1; s_arc = 0; s_ara = araddr; end
                    else s_arc++;
                end
                if (rvalid && rready) s_rhs = 1;
            end
        end
    end

    // Transaction-level model of the bridge: one outstanding request and the phases it has finished.
    logic          chk_en = 0;
    logic          m_busy = 0;
    logic          m_wr = 0, m_aw = 0, m_w = 0, m_b = 0, m_ar = 0, m_r = 0;
    logic [15:0]   m_addr = 0;
    logic [2:0]    m_prot = 0;
    logic [31:0]   m_data = 0;
    logic [3:0]    m_strb = 0;
    logic [31:0]   m_rdata = 0;
    logic [1:0]    m_resp = 0;
    logic [CW-1:0] m_cnt = 0;
    int            n_acc = 0;
    logic [31:0]   mem_m [64];

    initial begin
        logic e_aw, e_w, e_b, e_ar, e_r, e_rsp;
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
        forever begin
            @(negedge clk);
            #2;
            e_aw  = m_busy && m_wr && !m_aw;
            e_w   = m_busy && m_wr && !m_w;
            e_b   = m_busy && m_wr && m_aw && m_w && !m_b;
            e_ar  = m_busy && !m_wr && !m_ar;
            e_r   = m_busy && !m_wr && m_ar && !m_r;
            e_rsp = m_busy && (m_b || m_r);
            if (chk_en) begin
                chk("req_ready", req_ready, !m_busy);
                chk("txn_count", txn_count, m_cnt);
                chk("ctl aw/w/b/ar/r/rsp", {awvalid, wvalid, bready, arvalid, rready, rsp_valid},
                    {e_aw, e_w, e_b, e_ar, e_r, e_rsp});
                if (e_aw)  chk("aw_payload", {awaddr, awprot}, {m_addr, m_prot});
                if (e_w)   chk("w_payload", {wdata, wstrb}, {m_data, m_strb});
                if (e_ar)  chk("ar_payload", {araddr, arprot}, {m_addr, m_prot});
                if (e_rsp) chk("rsp_fields", {rsp_write, rsp_data, rsp_resp}, {m_wr, m_rdata, m_resp});
            end
            if (rst) begin
                m_busy = 0; m_cnt = 0;
            end else if (e_rsp && rsp_ready) begin
                m_busy = 0; m_cnt = m_cnt + 1'b1;
            end else if (m_busy) begin
                if (e_aw && awready) m_aw = 1;
                if (e_w && wready)   m_w  = 1;
                if (e_b && bvalid)   m_b  = 1;
                if (e_ar && arready) m_ar = 1;
                if (e_r && rvalid)   m_r  = 1;
            end else if (req_valid) begin
                m_busy = 1; n_acc++;
                m_wr = req_write; m_addr = req_addr; m_prot = req_prot;
                m_data = req_data; m_strb = req_strb;
                {m_aw, m_w, m_b, m_ar, m_r} = '0;
                if (req_write) begin
                    for (int b = 0; b < 4; b++)
                        if (req_strb[b]) mem_m[req_addr[7:2]][8*b +: 8] = req_data[8*b +: 8];
                    m_rdata = '0; m_resp = bresp_cfg;
                end else begin
                    m_rdata = mem_m[req_addr[7:2]]; m_resp = rresp_cfg;
                end
            end
        end
    end

    // One request through to its response; lat counts cycles from acceptance to first rsp_valid.
    task automatic do_txn(input logic wr, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p, input int hold,
                          output logic [31:0] rd, output logic [1:0] rr, output logic rw,
                          output int lat);
        int n;
        req_valid = 1; req_write = wr; req_addr = a; req_data = d; req_strb = s; req_prot = p;
        rsp_ready = (hold == 0);
        n = 0;
        do begin @(negedge clk); #2; n++; end while (!req_ready && n < 100);
        if (n >= 100) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 0;
        lat = 0;
        do begin @(negedge clk); #2; lat++; end while (!rsp_valid && lat < 100);
        if (lat >= 100) chk("rsp_timeout", 0, 1);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 rsp_ready = 1;
            @(negedge clk); #2;
        end
        rd = rsp_data; rr = rsp_resp; rw = rsp_write;
        @(posedge clk); #1;
        rsp_ready = 1;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr;
        logic        rw;
        int          lat;
        int          n;
        int          n0;
        int          exp6 [5];
        exp6 = '{1, 2, 3, 0, 1};

        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        @(negedge clk); #2;
        chk("reset req_ready", req_ready, 1);
        chk("reset txn_count", txn_count, 0);
        chk("reset valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        chk("reset regs", {rsp_data, rsp_resp, rsp_write, awaddr, wdata, wstrb, awprot}, 0);
        @(posedge clk); #1;

        // 1: basic write
        do_txn(1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'd0, 0, rd, rr, rw, lat);
        chk("t1 rsp", {rw, rd, rr}, {1'b1, 32'h0, 2'b00});
        chk("t1 latency", lat, 3);
        chk("t1 txn_count", txn_count, 1);

        // 2: read back
        do_txn(0, 16'h0010, 32'h0, 4'h0, 3'd0, 0, rd, rr, rw, lat);
        chk("t2 rsp", {rw, rd, rr}, {1'b0, 32'hDEADBEEF, 2'b00});
        chk("t2 latency", lat, 3);

        // 3: W before AW, AW before W, both together
        aw_dly = 3; w_dly = 0;
        do_txn(1, 16'h0020, 32'hA5A50001, 4'hF, 3'd2, 0, rd, rr, rw, lat);
        chk("t3a latency", lat, 6);
        aw_dly = 0; w_dly = 3;
        do_txn(1, 16'h0024, 32'h0BADF00D, 4'hF, 3'd5, 0, rd, rr, rw, lat);
        chk("t3b latency", lat, 6);
        w_dly = 0;
        do_txn(1, 16'h0010, 32'h12345678, 4'h5, 3'd1, 0, rd, rr, rw, lat);
        chk("t3c latency", lat, 3);
        do_txn(0, 16'h0010, 32'h0, 4'h0, 3'd0, 0, rd, rr, rw, lat);
        chk("t3 strobe merge", rd, 32'hDE34BE78);

        // 4: stalled response with SLVERR read
        rresp_cfg = 2'b10;
        do_txn(0, 16'h0020, 32'h0, 4'h0, 3'd3, 5, rd, rr, rw, lat);
        chk("t4 rsp", {rw, rd, rr}, {1'b0, 32'hA5A50001, 2'b10});
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b11;
        do_txn(1, 16'h0030, 32'h55AA55AA, 4'hF, 3'd0, 0, rd, rr, rw, lat);
        chk("t4 decerr write", {rw, rr}, {1'b1, 2'b11});
        chk("t4 txn wrap", txn_count, 0);
        bresp_cfg = 2'b00;

        // 5: reset while AR is stalled
        ar_dly = 20;
        req_valid = 1; req_write = 0; req_addr = 16'h0024; req_prot = 3'd0; rsp_ready = 1;
        @(negedge clk); #2;
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk); #2;
        chk("t5 arvalid stalled", {arvalid, arready}, 2'b10);
        pulse_rst();
        @(negedge clk); #2;
        chk("t5 after reset", {arvalid, req_ready, txn_count}, {1'b0, 1'b1, 2'd0});
        @(posedge clk); #1;
        ar_dly = 0;
        do_txn(1, 16'h0024, 32'h11112222, 4'hF, 3'd0, 0, rd, rr, rw, lat);
        chk("t5 write after reset", {rw, rr, lat}, {1'b1, 2'b00, 32'd3});
        chk("t5 txn_count", txn_count, 1);

        // 6: back-to-back reads with req_valid held high
        pulse_rst();
        n0 = n_acc;
        req_valid = 1; req_write = 0; req_addr = 16'h0024; rsp_ready = 1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            do begin @(negedge clk); #2; n++; end while (!(rsp_valid && rsp_ready) && n < 50);
            @(posedge clk); #1;
            if (i == 4) req_valid = 0;
            chk($sformatf("t6 txn_count %0d", i), txn_count, exp6[i]);
            chk($sformatf("t6 rdata %0d", i), rsp_data, 32'h11112222);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t6 accepts", n_acc - n0, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/umi_lite_to_axil_m.md
Name: umi_lite_to_axil_m

Overview:
- Synthesizable AXI-lite master bridge. Accepts single-beat read/write requests on a simple valid/ready request stream and issues the matching AXI-lite transactions. Returns the completion on a valid/ready response stream.
- Sits directly upstream of the switchboard AXI-lite slave model: its m_axil_* ports connect straight to that model's s_axil_* ports.
- Exactly one transaction is outstanding at a time.

Parameters:
- DATA_WIDTH, 32, AXI/request data width; a multiple of 8.
- ADDR_WIDTH, 16, AXI/request address width.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
- CNT_WIDTH, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  address.
- req_prot  in  3  AXI prot value.
- req_data  in  DATA_WIDTH  write data; ignored for reads.
- req_strb  in  STRB_WIDTH  write strobes; ignored for reads.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_write  out  1  echo of req_write.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  bresp/rresp captured from AXI.
- txn_count  out  CNT_WIDTH  completed transactions, wrapping.
- m_axil_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI-lite master signals with the widths above (prot is 3, resp is 2).

Behaviour:
- States: IDLE, WRITE, WRESP, READ, RRESP, RSP.
- Reset: state is IDLE. All AXI valids, bready, rready, rsp_valid and txn_count are 0. Address, data, strobe, prot, rsp_data and rsp_resp registers are 0.
- req_ready = (state==IDLE), driven combinationally from state only; it never depends on req_valid.
- IDLE, on req_valid&req_ready:
  - Register addr, prot, data, strb and write.
  - Write: go to WRITE, with awvalid=1 and wvalid=1 on the next cycle.
  - Read: go to READ, with arvalid=1 on the next cycle.
- WRITE:
  - awvalid drops the cycle after the AW handshake; wvalid drops the cycle after the W handshake. The two handshakes are independent and may complete in the same cycle or in either order.
  - Once both handshakes are done, go to WRESP with bready=1.
  - Zero idle cycles between a handshake and leaving the state: if both complete in the same cycle, the next state is WRESP.
- WRESP: on bvalid&bready, capture bresp into rsp_resp, set rsp_data=0 and rsp_write=1, drop bready, go to RSP.
- READ: arvalid holds until arready. On the handshake, drop arvalid and go to RRESP with rready=1.
- RRESP: on rvalid&rready, capture rdata and rresp, set rsp_write=0, drop rready, go to RSP.
- RSP:
  - rsp_valid=1; response fields stay stable until rsp_valid&rsp_ready.
  - On that handshake: go to IDLE, clear rsp_valid, and increment txn_count (modulo 2^CNT_WIDTH).
- AXI valids never drop before their handshake. Payloads stay constant while valid is high.
- AXI payload outputs carry the registered request from acceptance onward.
- Minimum latency, with an always-ready slave and rsp_ready=1:
  - Read: accept at cycle 0, arvalid at 1, rready at 2, rvalid at 2, rsp_valid at 3, IDLE at 4.
  - Write: same, with bvalid arriving at 2.
- A slave returning b/r valid while the bridge is not in WRESP/RRESP is a protocol violation; it is not captured because bready/rready are 0.
- Error responses (SLVERR/DECERR) pass through unchanged and still count as completed transactions.
- Reset mid-operation:
  - Forces IDLE and drops all valids/readys in the cycle after rst is sampled high.
  - The in-flight transaction is abandoned and txn_count clears.
- txn_count wraps from 2^CNT_WIDTH-1 to 0.

Test Plan:
1. Always-ready slave, write addr=0x0010, data=0xDEADBEEF, strb=0xF → AW/W fire at cycle 1. Response: rsp_write=1, rsp_resp=0, rsp_data=0. txn_count reaches 1.
2. Read addr=0x0010 where the slave returns 0xDEADBEEF with rresp=0 → rsp_data=0xDEADBEEF, rsp_write=0, rsp_valid asserted 3 cycles after acceptance.
3. Slave asserts wready 3 cycles before awready → wvalid drops first, awvalid holds until its own handshake, and WRESP is entered only afterwards. Repeat with awready first, then with both in the same cycle.
4. rsp_ready held low for 5 cycles with rresp=2'b10 → rsp_valid and all fields stable for 5 cycles, req_ready=0 throughout, and rsp_resp=2'b10 on the handshake.
5. Assert rst for 1 cycle while arvalid=1 and arready=0 → next cycle arvalid=0, req_ready=1 and txn_count=0. A subsequent write completes normally.
6. CNT_WIDTH=2, 5 back-to-back reads → txn_count steps 1, 2, 3, 0, 1. req_valid held high is accepted exactly once per transaction.
